lag_scan_sequencer: RTL and testbench

Sequencer that automates lag sweeps of the correlator. For one selected input it steps the lag offset from a start value to a stop value. At each step it waits for the delay line to settle, clears the counters, and integrates for a programmed number of sample ticks. It then requests one packet from the packet generator and waits for acknowledge before advancing. It sits between the command parser and the correlator/packet-generator datapath, replacing the free-running per-packet lag increment of test mode.

---
 rtl/lag_scan_sequencer_pkg.sv | 21 ++
 rtl/lag_scan_sequencer_tick_timer.sv | 31 +++
 rtl/lag_scan_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_lag_scan_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lag_scan_sequencer_pkg.sv
// Shared types and default sizes for the lag sweep sequencer.
package lag_scan_pkg;

  // Default geometry of the correlator datapath the sequencer drives.
  localparam int NUM_INPUTS_DEF   = 8;
  localparam int LINE_WIDTH       = 8;
  localparam int LAG_WIDTH_DEF    = 12;
  localparam int MAX_LAG_DEF      = 512;
  localparam int DWELL_WIDTH_DEF  = 24;
  localparam int SETTLE_TICKS_DEF = 4;

  // Sweep phases: wait for the delay line, clear counters, integrate, hand off a packet.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETTLE    = 3'd1,
    ST_CLEAR     = 3'd2,
    ST_INTEGRATE = 3'd3,
    ST_REPORT    = 3'd4
  } scan_state_t;

endpackage

// File: rtl/lag_scan_sequencer_tick_timer.sv
// Loadable down-counter of sample ticks; shared by the settle and dwell phases.
module tick_timer
  import lag_scan_pkg::*;
#(
  parameter int WIDTH = DWELL_WIDTH_DEF
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             smp_tick,
  output logic             expired
);

  logic [WIDTH-1:0] count_reg;

  // A load wins over a tick in the same cycle, so the tick seen on state entry is never counted.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (smp_tick && (count_reg != '0)) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  // Expiry fires in the cycle of the final counted tick so the caller can leave on that edge.
  assign expired = !load && smp_tick && (count_reg == WIDTH'(1));

endmodule

// File: rtl/lag_scan_sequencer.sv
// Steps one correlator line through a lag range: settle, clear, integrate, report per lag.
module lag_scan_sequencer
  import lag_scan_pkg::*;
#(
  parameter int NUM_INPUTS   = NUM_INPUTS_DEF,
  parameter int LAG_WIDTH    = LAG_WIDTH_DEF,
  parameter int MAX_LAG      = MAX_LAG_DEF,
  parameter int DWELL_WIDTH  = DWELL_WIDTH_DEF,
  parameter int SETTLE_TICKS = SETTLE_TICKS_DEF
) (
  input  logic                   sysclk,
  input  logic                   reset_n,
  input  logic                   smp_tick,
  input  logic                   start,
  input  logic                   abort,
  input  logic [LINE_WIDTH-1:0]  line_sel,
  input  logic [LAG_WIDTH-1:0]   lag_start,
  input  logic [LAG_WIDTH-1:0]   lag_stop,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [LAG_WIDTH-1:0]   lag_out,
  output logic [LINE_WIDTH-1:0]  lag_line,
  output logic                   lag_valid,
  output logic                   counter_clear,
  output logic                   integrating,
  output logic                   tx_req,
  input  logic                   tx_ack,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
);

  // Range limits widened by one bit so the comparisons cannot wrap.
  localparam logic [LAG_WIDTH:0]   MAX_LAG_EXT    = (LAG_WIDTH+1)'(MAX_LAG);
  localparam logic [LINE_WIDTH:0]  NUM_INPUTS_EXT = (LINE_WIDTH+1)'(NUM_INPUTS);
  // A zero settle count would never expire; one tick is the shortest meaningful wait.
  localparam logic [DWELL_WIDTH-1:0] SETTLE_LOAD =
    (SETTLE_TICKS < 1) ? DWELL_WIDTH'(1) : DWELL_WIDTH'(SETTLE_TICKS);

  scan_state_t            state_reg;
  logic [LAG_WIDTH-1:0]   lag_out_reg;
  logic [LAG_WIDTH-1:0]   lag_stop_reg;
  logic [LINE_WIDTH-1:0]  lag_line_reg;
  logic [DWELL_WIDTH-1:0] dwell_reg;
  logic                   busy_reg;
  logic                   counter_clear_reg;
  logic                   integrating_reg;
  logic                   tx_req_reg;
  logic                   done_reg;
  logic                   cfg_err_reg;

  logic [DWELL_WIDTH-1:0] dwell_eff;
  logic [DWELL_WIDTH-1:0] timer_value;
  logic                   timer_load;
  logic                   timer_expired;
  logic                   cfg_bad;
  logic                   last_step;

  // Requests are validated against the live inputs at the moment of the start pulse.
  assign cfg_bad = (lag_start > lag_stop) ||
                   ({1'b0, lag_stop} >= MAX_LAG_EXT) ||
                   ({1'b0, line_sel} >= NUM_INPUTS_EXT);

  // A dwell of zero behaves as a one-tick integration.
  assign dwell_eff = (dwell_reg == '0) ? DWELL_WIDTH'(1) : dwell_reg;
  assign last_step = (lag_out_reg == lag_stop_reg);

  // Arm the shared timer on every edge that enters SETTLE or INTEGRATE.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = SETTLE_LOAD;
    case (state_reg)
      ST_IDLE: begin
        timer_load = start && !cfg_bad;
      end
      ST_CLEAR: begin
        timer_load  = 1'b1;
        timer_value = dwell_eff;
      end
      ST_REPORT: begin
        timer_load = tx_ack && !last_step;
      end
      default: begin
        timer_load = 1'b0;
      end
    endcase
  end

  tick_timer #(
    .WIDTH(DWELL_WIDTH)
  ) u_tick_timer (
    .sysclk    (sysclk),
    .reset_n   (reset_n),
    .load      (timer_load),
    .load_value(timer_value),
    .smp_tick  (smp_tick),
    .expired   (timer_expired)
  );

  // Sweep FSM with registered outputs; abort overrides every other event, including start.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= ST_IDLE;
      lag_out_reg       <= '0;
      lag_stop_reg      <= '0;
      lag_line_reg      <= '0;
      dwell_reg         <= '0;
      busy_reg          <= 1'b0;
      counter_clear_reg <= 1'b0;
      integrating_reg   <= 1'b0;
      tx_req_reg        <= 1'b0;
      done_reg          <= 1'b0;
      cfg_err_reg       <= 1'b0;
    end else begin
      counter_clear_reg <= 1'b0;
      done_reg          <= 1'b0;
      if (abort) begin
        // The lag value is left in place so the line keeps its last applied offset.
        state_reg       <= ST_IDLE;
        busy_reg        <= 1'b0;
        integrating_reg <= 1'b0;
        tx_req_reg      <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start) begin
              if (cfg_bad) begin
                cfg_err_reg <= 1'b1;
              end else begin
                cfg_err_reg  <= 1'b0;
                lag_line_reg <= line_sel;
                lag_stop_reg <= lag_stop;
                dwell_reg    <= dwell;
                lag_out_reg  <= lag_start;
                busy_reg     <= 1'b1;
                state_reg    <= ST_SETTLE;
              end
            end
          end
          ST_SETTLE: begin
            if (timer_expired) begin
              counter_clear_reg <= 1'b1;
              state_reg         <= ST_CLEAR;
            end
          end
          ST_CLEAR: begin
            integrating_reg <= 1'b1;
            state_reg       <= ST_INTEGRATE;
          end
          ST_INTEGRATE: begin
            if (timer_expired) begin
              integrating_reg <= 1'b0;
              tx_req_reg      <= 1'b1;
              state_reg       <= ST_REPORT;
            end
          end
          ST_REPORT: begin
            if (tx_ack) begin
              tx_req_reg <= 1'b0;
              if (last_step) begin
                done_reg  <= 1'b1;
                busy_reg  <= 1'b0;
                state_reg <= ST_IDLE;
              end else begin
                lag_out_reg <= lag_out_reg + LAG_WIDTH'(1);
                state_reg   <= ST_SETTLE;
              end
            end
          end
          default: begin
            state_reg       <= ST_IDLE;
            busy_reg        <= 1'b0;
            integrating_reg <= 1'b0;
            tx_req_reg      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign lag_out       = lag_out_reg;
  assign lag_line      = lag_line_reg;
  assign lag_valid     = busy_reg;
  assign busy          = busy_reg;
  assign counter_clear = counter_clear_reg;
  assign integrating   = integrating_reg;
  assign tx_req        = tx_req_reg;
  assign done          = done_reg;
  assign cfg_err       = cfg_err_reg;

endmodule

// File: tb/tb_lag_scan_sequencer.sv
// Scoreboard bench for the lag sweep sequencer: expected events queued by stimulus, popped by a monitor.
module tb_lag_scan_sequencer;

  localparam int LW = 12;
  localparam int DW = 24;

  logic          sysclk    = 1'b0;
  logic          reset_n   = 1'b0;
  logic          smp_tick  = 1'b0;
  logic          start     = 1'b0;
  logic          abort     = 1'b0;
  logic          tx_ack    = 1'b0;
  logic [7:0]    line_sel  = '0;
  logic [LW-1:0] lag_start = '0;
  logic [LW-1:0] lag_stop  = '0;
  logic [DW-1:0] dwell     = '0;
  logic [LW-1:0] lag_out;
  logic [7:0]    lag_line;
  logic          lag_valid, counter_clear, integrating, tx_req, busy, done, cfg_err;

  int checks = 0;
  int fails  = 0;
  int ack_delay = 0;
  bit ack_en = 1'b1;

  // kind: 0 = counter clear, 1 = packet request completed, 2 = done pulse
  typedef struct {
    int kind;
    int lag;
    int ticks;
    int cycles;
    int lag_after;
  } ev_t;
  ev_t exp_q[$];

  lag_scan_sequencer dut (
    .sysclk       (sysclk),
    .reset_n      (reset_n),
    .smp_tick     (smp_tick),
    .start        (start),
    .abort        (abort),
    .line_sel     (line_sel),
    .lag_start    (lag_start),
    .lag_stop     (lag_stop),
    .dwell        (dwell),
    .lag_out      (lag_out),
    .lag_line     (lag_line),
    .lag_valid    (lag_valid),
    .counter_clear(counter_clear),
    .integrating  (integrating),
    .tx_req       (tx_req),
    .tx_ack       (tx_ack),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input int k, input int lag, input int t, input int c, input int la);
    ev_t e;
    e.kind = k; e.lag = lag; e.ticks = t; e.cycles = c; e.lag_after = la;
    exp_q.push_back(e);
  endtask

  // Hand-derived event list for a sweep: clear then request per lag, done after the last.
  task automatic expect_sweep(input int s, input int p, input int tk, input int cyc);
    for (int l = s; l <= p; l++) begin
      push_ev(0, l, 0, 0, 0);
      push_ev(1, l, tk, cyc, (l == p) ? l : l + 1);
      if (l == p) push_ev(2, l, 0, 0, 0);
    end
  endtask

  task automatic pop_cmp(input int k, input int lag, input int t, input int c, input int la);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d lag %0d, expected no event", k, lag);
    end else begin
      e = exp_q.pop_front();
      $display("event kind=%0d lag=%0d ticks=%0d req_cycles=%0d lag_after=%0d", k, lag, t, c, la);
      chk("event_kind", k, e.kind);
      if (k == e.kind) begin
        chk("event_lag", lag, e.lag);
        if (k == 1) begin
          chk("integrate_ticks", t, e.ticks);
          chk("tx_req_cycles", c, e.cycles);
          chk("lag_after_ack", la, e.lag_after);
        end
      end
    end
  endtask

  // Sample ticks: one-cycle pulse every fourth clock.
  initial begin
    forever begin
      repeat (3) @(posedge sysclk);
      #1 smp_tick = 1'b1;
      @(posedge sysclk);
      #1 smp_tick = 1'b0;
    end
  end

  // Packet generator model: acknowledge each request after ack_delay extra cycles.
  initial begin
    forever begin
      @(negedge sysclk);
      if (tx_req && ack_en) begin
        for (int i = 0; i < ack_delay; i++) begin
          @(negedge sysclk);
          if (!tx_req) break;
        end
        if (tx_req) begin
          tx_ack = 1'b1;
          @(posedge sysclk);
          #1 tx_ack = 1'b0;
        end
      end
    end
  end

  // Monitor: turns DUT output activity into events and checks them against the queue.
  initial begin
    int integ_ticks;
    int req_len;
    int req_lag;
    bit req_act;
    integ_ticks = 0; req_len = 0; req_lag = 0; req_act = 1'b0;
    forever begin
      @(negedge sysclk);
      if (!reset_n) begin
        integ_ticks = 0; req_len = 0; req_act = 1'b0;
      end else begin
        chk("lag_valid_eq_busy", int'(lag_valid), int'(busy));
        if (counter_clear) begin
          pop_cmp(0, int'(lag_out), 0, 0, 0);
          integ_ticks = 0;
        end
        if (integrating && smp_tick) integ_ticks++;
        if (tx_req && !req_act) begin
          req_act = 1'b1;
          req_lag = int'(lag_out);
          req_len = 0;
        end
        if (tx_req) begin
          req_len++;
          chk("lag_hold_during_req", int'(lag_out), req_lag);
        end else if (req_act) begin
          req_act = 1'b0;
          pop_cmp(1, req_lag, integ_ticks, req_len, int'(lag_out));
        end
        if (done) begin
          pop_cmp(2, int'(lag_out), 0, 0, 0);
          chk("busy_at_done", int'(busy), 0);
        end
      end
    end
  end

  task automatic do_start(input int ls, input int s, input int p, input int d, input bit accept);
    @(posedge sysclk);
    #1;
    line_sel = 8'(ls); lag_start = LW'(s); lag_stop = LW'(p); dwell = DW'(d); start = 1'b1;
    @(posedge sysclk);
    #1;
    start = 1'b0;
    // Scramble the inputs so a design that keeps reading them instead of its shadow copy misbehaves.
    line_sel = 8'hff; lag_start = '1; lag_stop = '0; dwell = '0;
    if (accept) begin
      chk("start_busy", int'(busy), 1);
      chk("start_lag_out", int'(lag_out), s);
      chk("start_lag_line", int'(lag_line), ls);
      chk("start_cfg_err", int'(cfg_err), 0);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge sysclk);
      #1;
      n++;
    end while ((busy || exp_q.size() != 0) && n < budget);
    checks++;
    if (busy || exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout: busy %0d, pending events %0d, expected idle with 0 pending",
               name, busy, exp_q.size());
    end
  endtask

  task automatic chk_all_zero(input string tag);
    $display("check outputs zero: %s", tag);
    chk("zero_lag_out", int'(lag_out), 0);
    chk("zero_lag_line", int'(lag_line), 0);
    chk("zero_lag_valid", int'(lag_valid), 0);
    chk("zero_counter_clear", int'(counter_clear), 0);
    chk("zero_integrating", int'(integrating), 0);
    chk("zero_tx_req", int'(tx_req), 0);
    chk("zero_busy", int'(busy), 0);
    chk("zero_done", int'(done), 0);
    chk("zero_cfg_err", int'(cfg_err), 0);
  endtask

  int bad_line[3] = '{2, 2, 8};
  int bad_s[3]    = '{0, 6, 0};
  int bad_p[3]    = '{512, 5, 3};

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge sysclk);
    chk_all_zero("in_reset");
    @(negedge sysclk);
    #2 reset_n = 1'b1;
    @(negedge sysclk);
    chk_all_zero("after_reset");

    // Normal sweep 3..5, dwell 10, immediate acknowledge
    expect_sweep(3, 5, 10, 1);
    do_start(2, 3, 5, 10, 1'b1);
    wait_idle("normal_sweep", 1500);
    chk("normal_final_lag", int'(lag_out), 5);

    // Single step at lag 0 with dwell 0 (one tick)
    expect_sweep(0, 0, 1, 1);
    do_start(0, 0, 0, 0, 1'b1);
    wait_idle("zero_step", 500);

    // Configuration errors, each followed by a boundary-valid sweep that clears cfg_err
    for (int i = 0; i < 3; i++) begin
      do_start(bad_line[i], bad_s[i], bad_p[i], 5, 1'b0);
      chk("cfg_err_set", int'(cfg_err), 1);
      chk("cfg_err_busy", int'(busy), 0);
      repeat (4) @(negedge sysclk);
      chk("cfg_err_still_idle", int'(busy), 0);
      expect_sweep(511, 511, 1, 1);
      do_start(7, 511, 511, 1, 1'b1);
      wait_idle("cfg_recover", 500);
    end

    // Delayed acknowledge: tx_req held 50 cycles, lag_out stable until after ack
    ack_delay = 49;
    expect_sweep(7, 8, 2, 50);
    do_start(3, 7, 8, 2, 1'b1);
    wait_idle("delayed_ack", 1500);
    ack_delay = 0;

    // Abort during INTEGRATE of step 2
    push_ev(0, 3, 0, 0, 0);
    push_ev(1, 3, 10, 1, 4);
    push_ev(0, 4, 0, 0, 0);
    do_start(4, 3, 6, 10, 1'b1);
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (!(integrating && lag_out == LW'(4)) && n < 500);
    chk("abort_reach_integrate", int'(integrating && lag_out == LW'(4)), 1);
    repeat (3) @(negedge sysclk);
    @(posedge sysclk);
    #1 abort = 1'b1;
    @(posedge sysclk);
    #1 abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_integrating", int'(integrating), 0);
    chk("abort_tx_req", int'(tx_req), 0);
    chk("abort_lag_hold", int'(lag_out), 4);
    repeat (80) @(negedge sysclk);
    #1;
    chk("abort_pending_events", exp_q.size(), 0);
    chk("abort_lag_hold_later", int'(lag_out), 4);
    expect_sweep(3, 5, 10, 1);
    do_start(4, 3, 5, 10, 1'b1);
    wait_idle("after_abort", 1500);

    // start and abort together: no sweep
    @(posedge sysclk);
    #1;
    line_sel = 8'd1; lag_start = LW'(1); lag_stop = LW'(1); dwell = DW'(1);
    start = 1'b1; abort = 1'b1;
    @(posedge sysclk);
    #1 start = 1'b0; abort = 1'b0;
    chk("collide_busy", int'(busy), 0);
    repeat (60) @(negedge sysclk);
    chk("collide_busy_later", int'(busy), 0);

    // start while busy is ignored
    expect_sweep(10, 11, 3, 1);
    do_start(1, 10, 11, 3, 1'b1);
    repeat (10) @(negedge sysclk);
    @(posedge sysclk);
    #1;
    line_sel = 8'd5; lag_start = LW'(20); lag_stop = LW'(30); dwell = DW'(1); start = 1'b1;
    @(posedge sysclk);
    #1 start = 1'b0;
    chk("busy_start_line", int'(lag_line), 1);
    chk("busy_start_lag", int'(lag_out), 10);
    chk("busy_start_busy", int'(busy), 1);
    wait_idle("start_while_busy", 1500);

    // Asynchronous reset while waiting in REPORT
    ack_en = 1'b0;
    push_ev(0, 1, 0, 0, 0);
    do_start(0, 1, 2, 1, 1'b1);
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (!tx_req && n < 500);
    chk("reach_report", int'(tx_req), 1);
    #2 reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (2) @(negedge sysclk);
    #2 reset_n = 1'b1;
    ack_en = 1'b1;
    @(negedge sysclk);
    chk_all_zero("after_async_reset");
    chk("final_pending_events", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
